// File: rtl/pll_phase_ctrl_if.sv
// Request and PLL dynamic-phase pin bundle for pll_phase_ctrl.
// The master side is the requester and PLL model, and the slave side is the controller.
interface pll_phase_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_sel;
  logic       req_dir;
  logic [7:0] req_steps;
  logic       locked;
  logic [1:0] phasesel;
  logic       phasedir;
  logic       phasestep;
  logic       phaseloadreg;
  logic       done;
  logic       err;
  logic       busy;

  modport master (
    output req_valid, req_sel, req_dir, req_steps, locked,
    input  req_ready, phasesel, phasedir, phasestep, phaseloadreg, done, err, busy
  );

  modport slave (
    input  req_valid, req_sel, req_dir, req_steps, locked,
    output req_ready, phasesel, phasedir, phasestep, phaseloadreg, done, err, busy
  );
endinterface

// File: rtl/pll_phase_ctrl.sv
// Drives PLL dynamic phase-shift pins: it emits N timed low phasestep pulses
// and then waits, with a timeout, for the synchronized lock to return.
module pll_phase_ctrl #(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 4,
  parameter int LOCK_TO   = 65535
) (
  input logic             clk,
  input logic             rst_n,
  pll_phase_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SETUP, STEP_LO, STEP_HI, LOCKWAIT} state_t;

  localparam logic [15:0] L_SETUP_END = 16'(SETUP_CYC - 1);
  localparam logic [15:0] L_PULSE_END = 16'(PULSE_CYC - 1);
  localparam logic [15:0] L_GAP_END   = 16'(GAP_CYC - 1);
  localparam logic [15:0] L_LOCK_END  = 16'(LOCK_TO - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_lock_meta;
  logic        r_lock_s;
  logic [1:0]  r_sel;
  logic        r_dir;
  logic [7:0]  r_left;
  logic [15:0] r_cnt;
  logic        r_done;
  logic        r_err;
  logic        w_accept;
  logic        w_timeout;

  assign w_accept  = (r_state == IDLE) && bus.req_valid;
  assign w_timeout = (r_state == LOCKWAIT) && !r_lock_s && (r_cnt == L_LOCK_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= bus.locked;
      r_lock_s    <= r_lock_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (bus.req_valid) w_next = SETUP;
      SETUP:    if (r_cnt == L_SETUP_END) w_next = (r_left != 8'd0) ? STEP_LO : LOCKWAIT;
      STEP_LO:  if (r_cnt == L_PULSE_END) w_next = STEP_HI;
      STEP_HI:  if (r_cnt == L_GAP_END) w_next = (r_left > 8'd1) ? STEP_LO : LOCKWAIT;
      LOCKWAIT: if (r_lock_s || w_timeout) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // One shared cycle counter restarts on every state change.
  // The remaining-step count drops at the end of each high gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_sel  <= '0;
      r_dir  <= 1'b0;
      r_left <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_cnt  <= ((w_next != r_state) || (r_state == IDLE)) ? '0 : r_cnt + 16'd1;
      r_done <= (r_state == LOCKWAIT) && (w_next == IDLE);
      if (w_accept) begin
        r_sel  <= bus.req_sel;
        r_dir  <= bus.req_dir;
        r_left <= bus.req_steps;
        r_err  <= 1'b0;
      end else begin
        if ((r_state == STEP_HI) && (r_cnt == L_GAP_END)) r_left <= r_left - 8'd1;
        if (w_timeout) r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.req_ready    = (r_state == IDLE);
    bus.busy         = (r_state != IDLE);
    bus.phasestep    = (r_state != STEP_LO);
    bus.phaseloadreg = 1'b1;
    bus.phasesel     = r_sel;
    bus.phasedir     = r_dir;
    bus.done         = r_done;
    bus.err          = r_err;
  end

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Randomized self-checking bench for pll_phase_ctrl against a timing model
// derived directly from the pulse, gap, setup and lock-wait rules.
module tb_pll_phase_ctrl;
  localparam int SETUP_CYC = 2;
  localparam int PULSE_CYC = 4;
  localparam int GAP_CYC   = 4;
  localparam int LOCK_TO   = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic obsStep[$];
  logic obsSel0[$];
  logic obsSel1[$];
  logic obsDir[$];
  logic obsLoad[$];
  logic obsErr[$];

  pll_phase_ctrl_if bus();

  pll_phase_ctrl #(
    .SETUP_CYC(SETUP_CYC), .PULSE_CYC(PULSE_CYC), .GAP_CYC(GAP_CYC), .LOCK_TO(LOCK_TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Expected phasestep level at sample s after a handshake requesting n steps.
  function automatic logic expStep(input int s, input int n);
    int k;
    if (s < SETUP_CYC) return 1'b1;
    k = s - SETUP_CYC;
    if (k >= n * (PULSE_CYC + GAP_CYC)) return 1'b1;
    return ((k % (PULSE_CYC + GAP_CYC)) >= PULSE_CYC) ? 1'b1 : 1'b0;
  endfunction

  function automatic int expDoneIdx(input int n, input bit lockOk);
    return SETUP_CYC + n * (PULSE_CYC + GAP_CYC) + (lockOk ? 1 : LOCK_TO);
  endfunction

  function automatic int waveErrors(input int n);
    int cnt = 0;
    foreach (obsStep[i]) if (obsStep[i] !== expStep(i, n)) cnt++;
    return cnt;
  endfunction

  function automatic int countLows();
    int   cnt = 0;
    logic prev = 1'b1;
    foreach (obsStep[i]) begin
      if (prev === 1'b1 && obsStep[i] === 1'b0) cnt++;
      prev = obsStep[i];
    end
    return cnt;
  endfunction

  function automatic int selDirErrors(input logic [1:0] sel, input logic dir, input int upto);
    int cnt = 0;
    for (int i = 0; i < upto && i < obsStep.size(); i++)
      if (obsSel0[i] !== sel[0] || obsSel1[i] !== sel[1] || obsDir[i] !== dir || obsLoad[i] !== 1'b1) cnt++;
    return cnt;
  endfunction

  task automatic startRequest(input logic [1:0] sel, input logic dir, input logic [7:0] steps);
    @(negedge clk);
    bus.req_sel   = sel;
    bus.req_dir   = dir;
    bus.req_steps = steps;
    bus.req_valid = 1'b1;
    @(posedge clk);
  endtask

  task automatic capture(input int budget, input bit holdValid, input int glitchEnd, output int doneIdx);
    obsStep.delete(); obsSel0.delete(); obsSel1.delete();
    obsDir.delete(); obsLoad.delete(); obsErr.delete();
    doneIdx = -1;
    for (int s = 0; s < budget; s++) begin
      @(negedge clk);
      obsStep.push_back(bus.phasestep);
      obsSel0.push_back(bus.phasesel[0]);
      obsSel1.push_back(bus.phasesel[1]);
      obsDir.push_back(bus.phasedir);
      obsLoad.push_back(bus.phaseloadreg);
      obsErr.push_back(bus.err);
      if (bus.done === 1'b1) begin
        doneIdx = s;
        break;
      end
      if (!holdValid) bus.req_valid = 1'b0;
      if (glitchEnd > 0) bus.locked = (s < glitchEnd) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_sel = 2'd0; bus.req_dir = 1'b0;
    bus.req_steps = 8'd0; bus.locked = 1'b1;
    #12;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", bus.req_ready); end
    checks++; if (bus.phasestep !== 1'b1) begin errors++; $display("[TB] FAIL reset_step got %b want 1", bus.phasestep); end
    checks++; if (bus.phaseloadreg !== 1'b1) begin errors++; $display("[TB] FAIL reset_load got %b want 1", bus.phaseloadreg); end
    checks++; if (bus.phasesel !== 2'd0 || bus.phasedir !== 1'b0) begin errors++; $display("[TB] FAIL reset_seldir got %b/%b want 00/0", bus.phasesel, bus.phasedir); end
    checks++; if (bus.done !== 1'b0 || bus.err !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags got done=%b err=%b busy=%b want 0", bus.done, bus.err, bus.busy); end
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_steps = 8'd3;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_ignores_req got busy=%b want 0", bus.busy); end
    bus.req_valid = 1'b0;
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic();
    int doneIdx;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_ready got %b want 1", bus.req_ready); end
    startRequest(2'd1, 1'b1, 8'd3);
    capture(200, 1'b0, 0, doneIdx);
    checks++; if (doneIdx !== expDoneIdx(3, 1'b1)) begin errors++; $display("[TB] FAIL basic_done_time got %0d want %0d", doneIdx, expDoneIdx(3, 1'b1)); end
    checks++; if (countLows() !== 3) begin errors++; $display("[TB] FAIL basic_pulses got %0d want 3", countLows()); end
    checks++; if (waveErrors(3) !== 0) begin errors++; $display("[TB] FAIL basic_wave got %0d bad samples want 0", waveErrors(3)); end
    checks++; if (selDirErrors(2'd1, 1'b1, doneIdx) !== 0) begin errors++; $display("[TB] FAIL basic_seldir got %0d bad samples want 0", selDirErrors(2'd1, 1'b1, doneIdx)); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL basic_err got %b want 0", bus.err); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_width got %b want 0", bus.done); end
  endtask

  task automatic test_zero_steps();
    int doneIdx;
    startRequest(2'd2, 1'b0, 8'd0);
    capture(50, 1'b0, 0, doneIdx);
    checks++; if (countLows() !== 0) begin errors++; $display("[TB] FAIL zero_pulses got %0d want 0", countLows()); end
    checks++; if (doneIdx !== expDoneIdx(0, 1'b1)) begin errors++; $display("[TB] FAIL zero_done_time got %0d want %0d", doneIdx, expDoneIdx(0, 1'b1)); end
    checks++; if (doneIdx < 0 || doneIdx >= SETUP_CYC + 4) begin errors++; $display("[TB] FAIL zero_done_bound got %0d want below %0d", doneIdx, SETUP_CYC + 4); end
  endtask

  // Random requests; lock is wiggled during the stepping phase and restored before lock-wait.
  task automatic test_random();
    int         doneIdx;
    int         n;
    int         l0;
    logic [1:0] sel;
    logic       dir;
    for (int it = 0; it < 6; it++) begin
      n   = $urandom_range(0, 20);
      sel = 2'($urandom_range(0, 3));
      dir = 1'($urandom_range(0, 1));
      l0  = SETUP_CYC + n * (PULSE_CYC + GAP_CYC);
      startRequest(sel, dir, 8'(n));
      capture(400, 1'b0, (n > 0) ? l0 - 4 : 0, doneIdx);
      checks++; if (doneIdx !== expDoneIdx(n, 1'b1)) begin errors++; $display("[TB] FAIL rand%0d_done_time got %0d want %0d", it, doneIdx, expDoneIdx(n, 1'b1)); end
      checks++; if (countLows() !== n || waveErrors(n) !== 0) begin errors++; $display("[TB] FAIL rand%0d_wave got %0d pulses %0d bad samples want %0d pulses 0 bad", it, countLows(), waveErrors(n), n); end
      checks++; if (selDirErrors(sel, dir, doneIdx) !== 0) begin errors++; $display("[TB] FAIL rand%0d_seldir got %0d bad samples want 0", it, selDirErrors(sel, dir, doneIdx)); end
      bus.locked = 1'b1;
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end
  endtask

  task automatic test_lock_timeout();
    int doneIdx;
    bus.locked = 1'b0;
    repeat (4) @(negedge clk);
    startRequest(2'd2, 1'b0, 8'd2);
    capture(200, 1'b0, 0, doneIdx);
    checks++; if (doneIdx !== expDoneIdx(2, 1'b0)) begin errors++; $display("[TB] FAIL timeout_done_time got %0d want %0d", doneIdx, expDoneIdx(2, 1'b0)); end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err got %b want 1", bus.err); end
    repeat (5) @(negedge clk);
    checks++; if (bus.err !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("[TB] FAIL timeout_sticky got err=%b done=%b want 1/0", bus.err, bus.done); end
    bus.locked = 1'b1;
    repeat (3) @(negedge clk);
    startRequest(2'd0, 1'b1, 8'd0);
    capture(50, 1'b0, 0, doneIdx);
    checks++; if (obsErr.size() == 0 || obsErr[0] !== 1'b0) begin errors++; $display("[TB] FAIL timeout_err_clear got %b want 0", (obsErr.size() == 0) ? 1'bx : obsErr[0]); end
  endtask

  task automatic test_mid_reset();
    int   lows = 0;
    int   after = 0;
    int   busyAfter = 0;
    logic prev = 1'b1;
    bit   hit = 1'b0;
    startRequest(2'd3, 1'b1, 8'd5);
    for (int s = 0; s < 100 && !hit; s++) begin
      @(negedge clk);
      if (prev === 1'b1 && bus.phasestep === 1'b0) lows++;
      prev = bus.phasestep;
      bus.req_valid = 1'b0;
      if (lows == 2 && bus.phasestep === 1'b0) hit = 1'b1;
    end
    checks++; if (!hit) begin errors++; $display("[TB] FAIL midreset_reach got lows=%0d want 2", lows); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.phasestep !== 1'b1 || bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_abort got step=%b busy=%b ready=%b want 1/0/1", bus.phasestep, bus.busy, bus.req_ready); end
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int s = 0; s < 60; s++) begin
      @(negedge clk);
      if (bus.phasestep !== 1'b1) after++;
      if (bus.busy !== 1'b0) busyAfter++;
    end
    checks++; if (after !== 0 || busyAfter !== 0) begin errors++; $display("[TB] FAIL midreset_quiet got %0d low and %0d busy samples want 0", after, busyAfter); end
  endtask

  task automatic test_back_to_back();
    int doneIdx;
    startRequest(2'd3, 1'b0, 8'd255);
    capture(3000, 1'b1, 0, doneIdx);
    checks++; if (doneIdx !== expDoneIdx(255, 1'b1)) begin errors++; $display("[TB] FAIL b2b_done_time got %0d want %0d", doneIdx, expDoneIdx(255, 1'b1)); end
    checks++; if (countLows() !== 255) begin errors++; $display("[TB] FAIL b2b_pulses got %0d want 255", countLows()); end
    checks++; if (waveErrors(255) !== 0) begin errors++; $display("[TB] FAIL b2b_wave got %0d bad samples want 0", waveErrors(255)); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle got busy=%b done=%b want 0/0", bus.busy, bus.done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_steps();
    test_random();
    test_lock_timeout();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog got timeout want completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/pll_phase_ctrl.md
PLL_PHASE_CTRL -- requirements
Module: pll_phase_ctrl

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2, meaning cycles that sel/dir are held stable before the first step pulse (minimum 1).
REQ-002 SHALL have parameter PULSE_CYC, default 4, meaning width in cycles of each low step pulse (minimum 1).
REQ-003 SHALL have parameter GAP_CYC, default 4, meaning high cycles after each step pulse (minimum 1).
REQ-004 SHALL have parameter LOCK_TO, default 65535, meaning the maximum cycles to wait for lock after the last step (16-bit range).
REQ-005 SHALL have port clk, input, 1, the single clock (PLL reference clock domain).
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port req_valid, input, 1, request strobe.
REQ-008 SHALL have port req_ready, output, 1, controller can accept a request.
REQ-009 SHALL have port req_sel, input, 2, PLL output to shift (0=OP, 1=OS, 2=OS2, 3=OS3).
REQ-010 SHALL have port req_dir, input, 1, 0=delay, 1=advance.
REQ-011 SHALL have port req_steps, input, 8, number of phase steps (0 legal).
REQ-012 SHALL have port locked, input, 1, PLL lock, asynchronous to clk.
REQ-013 SHALL have ports phasesel, output, 2; phasedir, output, 1; phasestep, output, 1; phaseloadreg, output, 1; all driving the PLL dynamic-phase pins.
REQ-014 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-015 SHALL have port err, output, 1, sticky lock-timeout flag.
REQ-016 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-017 SHALL pass locked through a 2-flop synchronizer; all lock decisions SHALL use the synchronized value (lock_s).
REQ-018 SHALL implement states IDLE, SETUP, STEP_LO, STEP_HI, LOCKWAIT.
REQ-019 SHALL assert req_ready only in IDLE; a handshake occurs on a cycle with req_valid=1 and req_ready=1.
REQ-020 On handshake, SHALL latch sel/dir/steps, drive phasesel/phasedir from the latched values on the next cycle, clear err, and enter SETUP.
REQ-021 In SETUP, SHALL hold for SETUP_CYC cycles, then enter STEP_LO if steps>0, otherwise LOCKWAIT.
REQ-022 In STEP_LO, SHALL drive phasestep=0 for exactly PULSE_CYC cycles, then enter STEP_HI.
REQ-023 In STEP_HI, SHALL drive phasestep=1 for GAP_CYC cycles and decrement the remaining-step count once per pulse; SHALL return to STEP_LO while steps remain, otherwise enter LOCKWAIT.
REQ-024 SHALL hold phasesel and phasedir constant from SETUP through the end of LOCKWAIT.
REQ-025 SHALL hold phaseloadreg=1 at all times (static-phase reload unused).
REQ-026 In LOCKWAIT, SHALL count cycles from 0; on lock_s=1, SHALL pulse done for one cycle and return to IDLE.
REQ-027 If LOCK_TO cycles elapse in LOCKWAIT without lock_s, SHALL set err, pulse done, and return to IDLE.
REQ-028 If lock_s falls during SETUP/STEP_LO/STEP_HI, SHALL complete the sequence unchanged; lock is evaluated only in LOCKWAIT.
REQ-029 SHALL ignore req_valid while busy; no request queueing.
REQ-030 Exactly N low phasestep pulses SHALL occur for req_steps=N; 255 steps SHALL work without counter wrap.
REQ-031 err SHALL remain set until the next accepted request or reset.

Reset
REQ-032 On rst_n=0, SHALL asynchronously enter IDLE with req_ready=1, phasestep=1, phaseloadreg=1, phasedir=0, phasesel=0, done=0, err=0, busy=0, and the synchronizer flops cleared.
REQ-033 Reset asserted mid-sequence SHALL abort immediately with no further step pulses after release.
REQ-034 Request latching and state changes SHALL occur only on the rising edge of clk after rst_n deasserts.

Verification
REQ-035 Default parameters, locked=1, request sel=1/dir=1/steps=3 -> three phasestep low pulses of 4 cycles separated by 4 high cycles; phasesel=1 and phasedir=1 throughout; done pulses once; err=0.
REQ-036 steps=0 with locked=1 -> no phasestep pulse; done pulses within SETUP_CYC+4 cycles of the handshake.
REQ-037 LOCK_TO=16, locked=0 after the steps -> err=1 and done pulse 16 cycles after LOCKWAIT entry; the next request clears err.
REQ-038 rst_n pulled low during the 2nd STEP_LO -> phasestep=1 and busy=0 immediately; no pulses after release.
REQ-039 req_valid held high while busy -> only one sequence executes per accepted handshake; steps=255 yields exactly 255 pulses.
